// File: rtl/alarm_ctrl.sv
// Alarm ring/snooze/stop controller: compares the stored alarm time with the
// running clock and drives the buzzer, honouring snooze and stop buttons.
module alarm_ctrl #(
    parameter int unsigned SNOOZE_MIN       = 5,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZES      = 3
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       alarm_enable,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       alarm_active,
    output logic       snoozing,
    output logic [1:0] snooze_used
);

    localparam int unsigned RING_W = 7;
    localparam int unsigned SNZ_W  = 12;

    localparam logic [SNZ_W-1:0]  SNOOZE_LOAD = SNZ_W'(SNOOZE_MIN * 60);
    localparam logic [RING_W-1:0] RING_LAST   = RING_W'(RING_TIMEOUT_SEC - 1);
    localparam logic [1:0]        USED_MAX    = 2'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t             state;
    logic [RING_W-1:0]  ring_sec;
    logic [SNZ_W-1:0]   snooze_sec;
    logic               match_c;

    assign match_c = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes);

    // State, counters and registered outputs all advance together.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            snoozing     <= 1'b0;
            snooze_used  <= 2'd0;
            ring_sec     <= '0;
            snooze_sec   <= '0;
        end else if (!alarm_enable) begin
            state        <= IDLE;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            snoozing     <= 1'b0;
            snooze_used  <= 2'd0;
            ring_sec     <= '0;
            snooze_sec   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match_c && (cur_seconds == 6'd0)) begin
                        state        <= RINGING;
                        buzzer       <= 1'b1;
                        alarm_active <= 1'b1;
                        snoozing     <= 1'b0;
                        ring_sec     <= '0;
                        snooze_used  <= 2'd0;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state        <= LOCKOUT;
                        buzzer       <= 1'b0;
                        alarm_active <= 1'b0;
                    end else if (snooze_btn && (snooze_used < USED_MAX)) begin
                        state        <= SNOOZE;
                        buzzer       <= 1'b0;
                        snoozing     <= 1'b1;
                        snooze_used  <= snooze_used + 2'd1;
                        snooze_sec   <= SNOOZE_LOAD;
                    end else if (tick_1hz) begin
                        if (ring_sec == RING_LAST) begin
                            state        <= LOCKOUT;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b0;
                        end else begin
                            buzzer   <= ~buzzer;
                            ring_sec <= ring_sec + RING_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state        <= LOCKOUT;
                        buzzer       <= 1'b0;
                        alarm_active <= 1'b0;
                        snoozing     <= 1'b0;
                    end else if (tick_1hz) begin
                        if (snooze_sec == SNZ_W'(1)) begin
                            state    <= RINGING;
                            buzzer   <= 1'b1;
                            snoozing <= 1'b0;
                            ring_sec <= '0;
                        end
                        snooze_sec <= snooze_sec - SNZ_W'(1);
                    end
                end
                LOCKOUT: begin
                    // Hold off until the alarm minute has passed to avoid re-triggering.
                    if (!match_c) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios followed by random button/tick
// traffic, checked against an event-level model of the alarm behaviour.
module tb_alarm_ctrl;

    localparam int unsigned RT = 4;
    localparam int unsigned SM = 1;
    localparam int unsigned MS = 1;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;
    localparam int M_LOCK = 3;

    logic       sys_clk       = 1'b0;
    logic       rst_n         = 1'b0;
    logic       tick_1hz      = 1'b0;
    logic       alarm_enable  = 1'b0;
    logic [4:0] cur_hours     = 5'd0;
    logic [5:0] cur_minutes   = 6'd0;
    logic [5:0] cur_seconds   = 6'd0;
    logic [4:0] alarm_hours   = 5'd0;
    logic [5:0] alarm_minutes = 6'd0;
    logic       snooze_btn    = 1'b0;
    logic       stop_btn      = 1'b0;
    logic       buzzer;
    logic       alarm_active;
    logic       snoozing;
    logic [1:0] snooze_used;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode, ticks rung in this bout, ticks slept in this snooze, snoozes used
    int m_mode  = M_IDLE;
    int m_rung  = 0;
    int m_slept = 0;
    int m_used  = 0;

    alarm_ctrl #(
        .SNOOZE_MIN       (SM),
        .RING_TIMEOUT_SEC (RT),
        .MAX_SNOOZES      (MS)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .tick_1hz      (tick_1hz),
        .alarm_enable  (alarm_enable),
        .cur_hours     (cur_hours),
        .cur_minutes   (cur_minutes),
        .cur_seconds   (cur_seconds),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .snooze_btn    (snooze_btn),
        .stop_btn      (stop_btn),
        .buzzer        (buzzer),
        .alarm_active  (alarm_active),
        .snoozing      (snoozing),
        .snooze_used   (snooze_used)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_rung  = 0;
        m_slept = 0;
        m_used  = 0;
    endfunction

    // Beeping alternates each second of a ringing bout, starting with the buzzer on.
    function automatic void model_edge();
        bit match;
        match = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes);
        if (!rst_n || !alarm_enable) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: if (match && cur_seconds == 6'd0) begin
                m_mode = M_RING; m_rung = 0; m_used = 0;
            end
            M_RING: begin
                if (stop_btn) m_mode = M_LOCK;
                else if (snooze_btn && m_used < MS) begin
                    m_mode = M_SNZ; m_used++; m_slept = 0;
                end else if (tick_1hz) begin
                    m_rung++;
                    if (m_rung == RT) m_mode = M_LOCK;
                end
            end
            M_SNZ: begin
                if (stop_btn) m_mode = M_LOCK;
                else if (tick_1hz) begin
                    m_slept++;
                    if (m_slept == SM * 60) begin
                        m_mode = M_RING; m_rung = 0;
                    end
                end
            end
            default: if (!match) m_mode = M_IDLE;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".buzzer"}, 32'(buzzer), 32'(m_mode == M_RING && (m_rung % 2) == 0));
        check({tag, ".active"}, 32'(alarm_active), 32'(m_mode == M_RING || m_mode == M_SNZ));
        check({tag, ".snoozing"}, 32'(snoozing), 32'(m_mode == M_SNZ));
        check({tag, ".used"}, 32'(snooze_used), 32'(m_used));
    endtask

    task automatic advance_time();
        if (cur_seconds == 6'd59) begin
            cur_seconds = 6'd0;
            if (cur_minutes == 6'd59) begin
                cur_minutes = 6'd0;
                cur_hours   = (cur_hours == 5'd23) ? 5'd0 : cur_hours + 5'd1;
            end else begin
                cur_minutes = cur_minutes + 6'd1;
            end
        end else begin
            cur_seconds = cur_seconds + 6'd1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hours   = 5'(h);
        cur_minutes = 6'(m);
        cur_seconds = 6'(s);
    endtask

    // One clock edge: update the model, check outputs, then retire pulses.
    task automatic step(input string tag);
        @(posedge sys_clk);
        model_edge();
        #1;
        compare_all(tag);
        if (tick_1hz) advance_time();
        tick_1hz   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
    endtask

    task automatic tick(input string tag);
        tick_1hz = 1'b1;
        step(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("reset");
        check("reset.buzzer_zero", 32'(buzzer), 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;

        // trigger and timeout
        alarm_hours = 5'd7; alarm_minutes = 6'd30; alarm_enable = 1'b1;
        set_time(7, 29, 59);
        step("pre");
        tick("pre_tick");
        check("pre.not_active", 32'(alarm_active), 32'd0);
        step("trig");
        check("trig.buzzer", 32'(buzzer), 32'd1);
        check("trig.active", 32'(alarm_active), 32'd1);
        tick("ring1");
        check("ring1.buzzer", 32'(buzzer), 32'd0);
        ticks(2, "ring");
        tick("timeout");
        check("timeout.active", 32'(alarm_active), 32'd0);
        check("timeout.buzzer", 32'(buzzer), 32'd0);
        ticks(56, "lockout");
        check("lockout.no_retrig", 32'(alarm_active), 32'd0);
        step("to_idle");

        // snooze, wake, ignored second snooze, stop
        set_time(7, 30, 0);
        step("retrig");
        check("retrig.active", 32'(alarm_active), 32'd1);
        snooze_btn = 1'b1;
        step("snooze");
        check("snooze.snoozing", 32'(snoozing), 32'd1);
        check("snooze.used", 32'(snooze_used), 32'd1);
        ticks(59, "sleep");
        check("sleep.still", 32'(snoozing), 32'd1);
        tick("wake");
        check("wake.buzzer", 32'(buzzer), 32'd1);
        check("wake.snoozing", 32'(snoozing), 32'd0);
        snooze_btn = 1'b1;
        step("snooze_again");
        check("snooze_again.buzzer", 32'(buzzer), 32'd1);
        stop_btn = 1'b1;
        step("stop");
        check("stop.active", 32'(alarm_active), 32'd0);
        step("idle2");

        // stop and snooze together: stop wins
        set_time(7, 30, 0);
        step("ring3");
        stop_btn = 1'b1; snooze_btn = 1'b1;
        step("both");
        check("both.active", 32'(alarm_active), 32'd0);
        check("both.used", 32'(snooze_used), 32'd0);
        set_time(7, 31, 0);
        step("idle3");

        // snooze coincident with tick, then disable while snoozing
        set_time(7, 30, 0);
        step("ring4");
        tick("ring4_t");
        snooze_btn = 1'b1; tick_1hz = 1'b1;
        step("snz_tick");
        check("snz_tick.snoozing", 32'(snoozing), 32'd1);
        alarm_enable = 1'b0;
        step("disable");
        check("disable.used", 32'(snooze_used), 32'd0);
        check("disable.active", 32'(alarm_active), 32'd0);
        set_time(7, 30, 0);
        step("dis_match");
        check("dis_match.active", 32'(alarm_active), 32'd0);
        alarm_enable = 1'b1;
        step("ring5");

        // async reset mid-ring
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("async_rst.buzzer", 32'(buzzer), 32'd0);
        check("async_rst.active", 32'(alarm_active), 32'd0);
        model_reset();
        step("in_rst");
        @(negedge sys_clk);
        rst_n = 1'b1;
        step("rearm");
        check("rearm.active", 32'(alarm_active), 32'd1);
        check("rearm.buzzer", 32'(buzzer), 32'd1);

        // random traffic around the alarm minute
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) set_time(7, 29, int'($urandom_range(50, 59)));
            if ($urandom_range(0, 299) == 0) alarm_minutes = 6'($urandom_range(29, 31));
            alarm_enable = ($urandom_range(0, 99) != 0);
            tick_1hz     = ($urandom_range(0, 2) == 0);
            snooze_btn   = ($urandom_range(0, 14) == 0);
            stop_btn     = ($urandom_range(0, 29) == 0);
            if (snooze_btn && !stop_btn && !(m_mode == M_RING && m_used < MS))
                tick_1hz = 1'b0;
            if (tick_1hz) step("rnd_tick");
            else          step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
